ysyx_22041752_wb_stage: RTL
===========================

YSYX_22041752_WB_STAGE -- requirements
Module: ysyx_22041752_wb_stage

Interface
REQ-001 SHALL have parameter: INSTRET_WD, 64, width of retired-instruction and stall counters.
REQ-002 SHALL have ports: clk  in  1  system clock; single clock domain.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: ms_to_ws_valid  in  1  mem stage holds a valid instruction.
REQ-005 SHALL have ports: ms_to_ws_bus  in  168  {is_load[167], pc[166:103], inst[102:71], rf_wen[70], rf_wnum[69:65], rf_wdata[64:1], is_ebreak[0]}.
REQ-006 SHALL have ports: data_rvalid  in  1  load data return strobe, one cycle.
REQ-007 SHALL have ports: data_rdata  in  64  load data, already aligned and extended.
REQ-008 SHALL have ports: ws_allowin  out  1  wb stage accepts a new instruction this cycle.
REQ-009 SHALL have ports: ws_to_rf_bus  out  70  {wen, wnum[68:64], wdata[63:0]} to register file.
REQ-010 SHALL have ports: ws_valid / debug_wb_pc(64) / debug_wb_inst(32) / debug_wb_rf_wen / debug_wb_rf_wnum(5) / debug_wb_rf_wdata(64)  out  commit trace for the DPI recorder.
REQ-011 SHALL have ports: stop  out  1  core halted on ebreak.
REQ-012 SHALL have ports: instret, stall_cnt  out  INSTRET_WD  performance counters.

Function
REQ-013 SHALL latch ms_to_ws_bus into internal registers when ms_to_ws_valid && ws_allowin, and set ws_valid_r on that edge.
REQ-014 SHALL compute ws_ready_go = !is_load || load_done, where load_done is set by data_rvalid while ws_valid_r and cleared on every new latch.
REQ-015 SHALL capture data_rdata into a load-data register on the data_rvalid cycle; a data_rvalid arriving in the same cycle as the latch is ignored.
REQ-016 SHALL assert ws_allowin = !ws_valid_r || (ws_ready_go && state==RUN), combinationally.
REQ-017 SHALL define commit = ws_valid_r && ws_ready_go && state==RUN; clear ws_valid_r on commit when no new latch occurs.
REQ-018 SHALL drive ws_valid = commit and the debug_wb_* outputs from the held instruction in the commit cycle; wdata = load-data register when is_load, else bus rf_wdata.
REQ-019 SHALL drive ws_to_rf_bus.wen = commit && rf_wen && (rf_wnum != 0); writes to x0 are suppressed.
REQ-020 SHALL implement FSM RUN -> HALT on commit of an instruction with is_ebreak=1; HALT is terminal until reset.
REQ-021 SHALL in HALT hold stop=1, ws_allowin=0, no further commit, no RF write.
REQ-022 SHALL increment instret by 1 per commit, wrapping modulo 2^INSTRET_WD.
REQ-023 SHALL increment stall_cnt each cycle ws_valid_r && !ws_ready_go && state==RUN, wrapping.
REQ-024 SHALL commit the ebreak itself (trace, RF write, instret) in the same cycle the FSM enters HALT.

Reset
REQ-025 SHALL on reset clear ws_valid_r, load_done, state=RUN, stop=0, instret=0, stall_cnt=0; all other outputs 0 while reset is high.
REQ-026 SHALL give reset priority over latch, commit and data_rvalid in the same cycle; an in-flight load is discarded.

Configuration
REQ-027 SHALL, with YSYX_22041752_PERF_EN defined, implement instret and stall_cnt per REQ-022/023.
REQ-028 SHALL, without YSYX_22041752_PERF_EN, tie instret and stall_cnt to 0 with no counter flops; all other behaviour unchanged.

Verification
REQ-029 SHALL cover: non-load addi, pc=0x80000000, wnum=5, wdata=0x2A -> next cycle ws_valid=1, debug_wb_pc=0x80000000, rf wen=1, instret=1.
REQ-030 SHALL cover: load latched, data_rvalid after 3 cycles with 0xDEADBEEF -> ws_allowin=0 and stall_cnt +3, commit wdata=0xDEADBEEF.
REQ-031 SHALL cover: rf_wen=1, wnum=0 -> ws_valid=1, ws_to_rf_bus wen=0.
REQ-032 SHALL cover: ebreak commit followed by valid instruction -> stop=1 from next cycle, ws_allowin=0, instret frozen.
REQ-033 SHALL cover: reset asserted while load waits -> next cycle ws_valid=0, state RUN, counters 0, late data_rvalid ignored.
REQ-034 SHALL cover: back-to-back valid non-loads for 10 cycles -> one commit per cycle, ws_allowin held 1, instret=10.

Source files
------------

// File: rtl/ysyx_22041752_wb_stage.sv
// rtl/ysyx_22041752_wb_stage.sv - write-back stage: load wait, commit trace, ebreak halt, perf counters
// Define YSYX_22041752_PERF_EN to build the instret/stall_cnt counters; otherwise both read 0.
module ysyx_22041752_wb_stage #(
   parameter int INSTRET_WD = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ms_to_ws_valid,
   input  logic [167:0]          ms_to_ws_bus,
   input  logic                  data_rvalid,
   input  logic [63:0]           data_rdata,
   output logic                  ws_allowin,
   output logic [69:0]           ws_to_rf_bus,
   output logic                  ws_valid,
   output logic [63:0]           debug_wb_pc,
   output logic [31:0]           debug_wb_inst,
   output logic                  debug_wb_rf_wen,
   output logic [4:0]            debug_wb_rf_wnum,
   output logic [63:0]           debug_wb_rf_wdata,
   output logic                  stop,
   output logic [INSTRET_WD-1:0] instret,
   output logic [INSTRET_WD-1:0] stall_cnt
);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t         state_q;
   state_t         state_d;

   logic           ws_valid_r;
   logic [167:0]   bus_r;
   logic           load_done;
   logic [63:0]    load_data_r;

   logic           is_load;
   logic [63:0]    pc;
   logic [31:0]    inst;
   logic           rf_wen;
   logic [4:0]     rf_wnum;
   logic [63:0]    rf_wdata;
   logic           is_ebreak;

   logic           ws_ready_go;
   logic           running;
   logic           commit;
   logic           latch;
   logic [63:0]    wdata;
   logic           rf_we;

   assign {is_load, pc, inst, rf_wen, rf_wnum, rf_wdata, is_ebreak} = bus_r;

   assign ws_ready_go = !is_load || load_done;
   assign running     = (state_q == RUN);
   // Combinational outputs are forced low while reset is held.
   assign ws_allowin  = !reset && running && (!ws_valid_r || ws_ready_go);
   assign commit      = !reset && running && ws_valid_r && ws_ready_go;
   assign latch       = ms_to_ws_valid && ws_allowin;

   assign wdata = is_load ? load_data_r : rf_wdata;
   assign rf_we = commit && rf_wen && (rf_wnum != 5'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         ws_valid_r <= 1'b0;
         load_done  <= 1'b0;
      end else if (latch) begin
         // A return strobe coinciding with a new latch belongs to nothing we hold.
         ws_valid_r <= 1'b1;
         bus_r      <= ms_to_ws_bus;
         load_done  <= 1'b0;
      end else begin
         if (commit)
            ws_valid_r <= 1'b0;
         if (data_rvalid && ws_valid_r) begin
            load_done   <= 1'b1;
            load_data_r <= data_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (commit && is_ebreak) state_d = HALT;
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
   end

   assign stop              = !reset && (state_q == HALT);
   assign ws_valid          = commit;
   assign ws_to_rf_bus      = reset ? 70'd0 : {rf_we, rf_wnum, wdata};
   assign debug_wb_pc       = reset ? 64'd0 : pc;
   assign debug_wb_inst     = reset ? 32'd0 : inst;
   assign debug_wb_rf_wen   = commit && rf_wen;
   assign debug_wb_rf_wnum  = reset ? 5'd0 : rf_wnum;
   assign debug_wb_rf_wdata = reset ? 64'd0 : wdata;

`ifdef YSYX_22041752_PERF_EN
   logic [INSTRET_WD-1:0] instret_q;
   logic [INSTRET_WD-1:0] stall_q;
   logic                  stalled;

   assign stalled = !reset && running && ws_valid_r && !ws_ready_go;

   always_ff @(posedge clk) begin
      if (reset) begin
         instret_q <= '0;
         stall_q   <= '0;
      end else begin
         if (commit)
            instret_q <= instret_q + INSTRET_WD'(1);
         if (stalled)
            stall_q <= stall_q + INSTRET_WD'(1);
      end
   end

   assign instret   = reset ? '0 : instret_q;
   assign stall_cnt = reset ? '0 : stall_q;
`else
   assign instret   = '0;
   assign stall_cnt = '0;
`endif

endmodule
